// File: rtl/alu_cmd_ctrl.sv
// Frame-based ALU command controller: SYNC, A, B, OP bytes in; result byte, then status byte, out.
// Latency: OP byte accepted in cycle N, ALU sampled in N+1, first o_tx_start in N+2.
// Backpressure: each tx byte waits indefinitely for i_tx_done; bytes arriving while busy are dropped and counted.
module alu_cmd_ctrl #(
  parameter int                MAXTAM        = 8,
  parameter int                TAM_OP        = 6,
  parameter logic [MAXTAM-1:0] SYNC          = MAXTAM'(8'hA5),
  parameter logic [15:0]       TIMEOUT_TICKS = 16'd4800
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_bd,
  input  logic              i_rx_done,
  input  logic [MAXTAM-1:0] i_rx_byte,
  input  logic [MAXTAM-1:0] i_alu_result,
  input  logic              i_alu_carry,
  input  logic              i_tx_done,
  output logic [MAXTAM-1:0] o_data_a,
  output logic [MAXTAM-1:0] o_data_b,
  output logic [TAM_OP-1:0] o_opcode,
  output logic              o_tx_start,
  output logic [MAXTAM-1:0] o_tx_byte,
  output logic              o_busy,
  output logic              o_err,
  output logic [7:0]        o_drop_cnt
);

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND_RES,
    WAIT_RES,
    SEND_STS,
    WAIT_STS
  } state_t;

  state_t            state;
  logic [MAXTAM-1:0] result_q;
  logic              carry_q;
  logic [15:0]       tmo_cnt;

  logic in_rx_state;
  logic in_tx_state;
  logic tmo_hit;

  // Receive phase is where the inter-byte timer runs; transmit phase is where bytes are dropped.
  assign in_rx_state = (state == GET_A) || (state == GET_B) || (state == GET_OP);
  assign in_tx_state = (state != IDLE) && !in_rx_state;
  // The tick that would bring the count to TIMEOUT_TICKS; an accepted byte in the same cycle wins.
  assign tmo_hit     = i_bd && (tmo_cnt == TIMEOUT_TICKS - 16'd1);

  // Frame FSM with registered outputs, timeout counter and drop counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_opcode   <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      o_tx_byte  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
      o_drop_cnt <= 8'd0;
      tmo_cnt    <= 16'd0;
    end else begin
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;

      if (in_tx_state && i_rx_done && (o_drop_cnt != 8'hFF))
        o_drop_cnt <= o_drop_cnt + 8'd1;

      if (in_rx_state && i_bd)
        tmo_cnt <= tmo_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (i_rx_done && (i_rx_byte == SYNC)) begin
            state   <= GET_A;
            o_busy  <= 1'b1;
            tmo_cnt <= 16'd0;
          end
        end
        GET_A, GET_B, GET_OP: begin
          if (i_rx_done) begin
            tmo_cnt <= 16'd0;
            if (state == GET_A) begin
              o_data_a <= i_rx_byte;
              state    <= GET_B;
            end else if (state == GET_B) begin
              o_data_b <= i_rx_byte;
              state    <= GET_OP;
            end else begin
              o_opcode <= i_rx_byte[TAM_OP-1:0];
              state    <= EXEC;
            end
          end else if (tmo_hit) begin
            // Abandon the frame; operands keep whatever was already latched.
            state   <= IDLE;
            o_busy  <= 1'b0;
            o_err   <= 1'b1;
            tmo_cnt <= 16'd0;
          end
        end
        EXEC: begin
          result_q   <= i_alu_result;
          carry_q    <= i_alu_carry;
          o_tx_byte  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= SEND_RES;
        end
        SEND_RES: begin
          // i_tx_done is deliberately not looked at in the start cycle.
          o_tx_byte <= result_q;
          state     <= WAIT_RES;
        end
        WAIT_RES: begin
          if (i_tx_done) begin
            o_tx_byte  <= MAXTAM'({4'hC, 3'b000, carry_q});
            o_tx_start <= 1'b1;
            state      <= SEND_STS;
          end
        end
        SEND_STS: begin
          state <= WAIT_STS;
        end
        WAIT_STS: begin
          if (i_tx_done) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed frames plus randomized frames against a reference ALU.
// Latency: checks that the result byte starts two cycles after the opcode byte.
// Backpressure: i_tx_done is delayed, made coincident with o_tx_start, or withheld across reset.
module tb_alu_cmd_ctrl;

  localparam int T = 4800;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_bd = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic [7:0] i_alu_result;
  logic       i_alu_carry;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_opcode;
  logic       o_tx_start;
  logic [7:0] o_tx_byte;
  logic       o_busy;
  logic       o_err;
  logic [7:0] o_drop_cnt;

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  alu_cmd_ctrl dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_bd         (i_bd),
    .i_rx_done    (i_rx_done),
    .i_rx_byte    (i_rx_byte),
    .i_alu_result (i_alu_result),
    .i_alu_carry  (i_alu_carry),
    .i_tx_done    (i_tx_done),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .o_opcode     (o_opcode),
    .o_tx_start   (o_tx_start),
    .o_tx_byte    (o_tx_byte),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Cycle counter used to measure latency.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulse counters for tx starts and error pulses.
  always @(negedge i_clk) begin
    if (o_tx_start) start_cnt <= start_cnt + 1;
    if (o_err)      err_cnt   <= err_cnt + 1;
  end

  // Reference ALU: 9-bit {carry, result} from plain arithmetic.
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int s;
    case (op)
      6'h20:   begin s = int'(a) + int'(b); ref_alu = {(s > 255), s[7:0]}; end
      6'h22:   begin s = int'(a) - int'(b); ref_alu = {(s < 0), s[7:0]};   end
      6'h24:   ref_alu = {1'b0, a & b};
      6'h25:   ref_alu = {1'b0, a | b};
      6'h26:   ref_alu = {1'b0, a ^ b};
      default: ref_alu = 9'h000;
    endcase
  endfunction

  // External ALU driven combinationally from the DUT operand registers.
  always_comb {i_alu_carry, i_alu_result} = ref_alu(o_data_a, o_data_b, o_opcode);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_done   = 1'b1;
    i_rx_byte   = b;
    last_rx_cyc = cyc;
    @(posedge i_clk); #1;
    i_rx_done   = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
    i_bd = 1'b1;
    @(posedge i_clk); #1;
    i_bd = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge i_clk); #1;
    i_tx_done = 1'b1;
    @(posedge i_clk); #1;
    i_tx_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok, output logic [7:0] b, output int c);
    ok = 1'b0;
    b  = 8'h00;
    c  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      if (o_tx_start) begin
        ok = 1'b1;
        b  = o_tx_byte;
        c  = cyc;
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int inject, input bit coincident, input bit skip_head);
    logic [8:0] exp;
    logic [7:0] bt;
    bit         ok;
    bit         any;
    int         c;
    int         op_cyc;
    exp = ref_alu(a, b, opb[5:0]);
    if (!skip_head) begin
      send_byte(8'hA5);
      send_byte(a);
    end
    send_byte(b);
    send_byte(opb);
    op_cyc = last_rx_cyc;
    wait_start(ok, bt, c);
    check_eq("res_start_seen", 32'(ok), 1);
    check_eq("res_latency", c - op_cyc, 2);
    check_eq("res_byte", 32'(bt), 32'(exp[7:0]));
    check_eq("data_a", 32'(o_data_a), 32'(a));
    check_eq("data_b", 32'(o_data_b), 32'(b));
    check_eq("opcode", 32'(o_opcode), 32'(opb[5:0]));
    if (coincident) begin
      i_tx_done = 1'b1;
      @(posedge i_clk); #1;
      i_tx_done = 1'b0;
      any = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge i_clk);
        any = any | o_tx_start;
      end
      check_eq("coinc_no_start", 32'(any), 0);
      check_eq("coinc_busy", 32'(o_busy), 1);
    end
    for (int i = 0; i < inject; i++) send_byte(8'($urandom));
    check_eq("res_hold", 32'(o_tx_byte), 32'(exp[7:0]));
    pulse_tx_done();
    wait_start(ok, bt, c);
    check_eq("sts_start_seen", 32'(ok), 1);
    check_eq("sts_byte", 32'(bt), 32'({4'hC, 3'b000, exp[8]}));
    pulse_tx_done();
    @(negedge i_clk);
    check_eq("idle_busy", 32'(o_busy), 0);
  endtask

  initial begin
    logic [7:0] ops [5];
    logic [7:0] bt;
    bit         ok;
    int         c;
    int         s0;
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

    // Reset state
    repeat (3) @(negedge i_clk);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_tx_start", 32'(o_tx_start), 0);
    check_eq("rst_err", 32'(o_err), 0);
    check_eq("rst_drop", 32'(o_drop_cnt), 0);
    check_eq("rst_data_a", 32'(o_data_a), 0);
    check_eq("rst_data_b", 32'(o_data_b), 0);
    check_eq("rst_opcode", 32'(o_opcode), 0);
    check_eq("rst_tx_byte", 32'(o_tx_byte), 0);
    #2 i_reset = 1'b1;

    // Directed frames: 3+4, FF+1 with carry, SUB with coincident tx_done
    do_frame(8'h03, 8'h04, 8'h20, 0, 1'b0, 1'b0);
    do_frame(8'hFF, 8'h01, 8'h20, 0, 1'b0, 1'b0);
    do_frame(8'h09, 8'h05, 8'h22, 0, 1'b1, 1'b0);
    check_eq("drop_after_frames", 32'(o_drop_cnt), 0);

    // Non-SYNC bytes in IDLE are ignored and not counted
    send_byte(8'h34);
    send_byte(8'h5A);
    @(negedge i_clk);
    check_eq("idle_noise_busy", 32'(o_busy), 0);
    check_eq("idle_noise_drop", 32'(o_drop_cnt), 0);

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h12);
    repeat (T - 1) tick();
    @(negedge i_clk);
    check_eq("tmo_pre_err", err_cnt, 0);
    check_eq("tmo_pre_busy", 32'(o_busy), 1);
    tick();
    @(negedge i_clk);
    check_eq("tmo_err_pulse", 32'(o_err), 1);
    @(negedge i_clk);
    check_eq("tmo_err_low", 32'(o_err), 0);
    check_eq("tmo_busy", 32'(o_busy), 0);
    check_eq("tmo_err_cnt", err_cnt, 1);
    check_eq("tmo_keep_a", 32'(o_data_a), 32'h12);
    send_byte(8'h34);
    @(negedge i_clk);
    check_eq("tmo_next_ignored", 32'(o_busy), 0);
    check_eq("tmo_next_data_a", 32'(o_data_a), 32'h12);
    check_eq("tmo_drop", 32'(o_drop_cnt), 0);

    // Byte coincident with the terminal tick is accepted
    send_byte(8'hA5);
    repeat (T - 1) tick();
    @(posedge i_clk); #1;
    i_rx_done = 1'b1;
    i_rx_byte = 8'h5A;
    i_bd      = 1'b1;
    @(posedge i_clk); #1;
    i_rx_done = 1'b0;
    i_bd      = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_eq("race_busy", 32'(o_busy), 1);
    check_eq("race_data_a", 32'(o_data_a), 32'h5A);
    check_eq("race_no_err", err_cnt, 1);
    do_frame(8'h5A, 8'h33, 8'h25, 0, 1'b0, 1'b1);

    // Randomized frames with IDLE noise and random opcode upper bits
    for (int n = 0; n < 20; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      for (int i = 0; i < k; i++) send_byte(8'h00 | 8'($urandom_range(0, 8'hA4)));
      do_frame(8'($urandom), 8'($urandom),
               {2'($urandom), ops[$urandom_range(0, 4)][5:0]},
               0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Drops during WAIT_RES, then saturation
    do_frame(8'h10, 8'h20, 8'h26, 3, 1'b0, 1'b0);
    check_eq("drop_3", 32'(o_drop_cnt), 3);
    do_frame(8'hC8, 8'h64, 8'h20, 300, 1'b0, 1'b0);
    check_eq("drop_sat", 32'(o_drop_cnt), 255);

    // Reset while waiting for the result byte to finish
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h08);
    send_byte(8'h20);
    wait_start(ok, bt, c);
    check_eq("rr_start_seen", 32'(ok), 1);
    @(posedge i_clk); #3;
    i_reset = 1'b0;
    #1;
    check_eq("rr_busy", 32'(o_busy), 0);
    check_eq("rr_tx_start", 32'(o_tx_start), 0);
    check_eq("rr_tx_byte", 32'(o_tx_byte), 0);
    check_eq("rr_data_a", 32'(o_data_a), 0);
    check_eq("rr_opcode", 32'(o_opcode), 0);
    check_eq("rr_drop", 32'(o_drop_cnt), 0);
    s0 = start_cnt;
    #2 i_reset = 1'b1;
    pulse_tx_done();
    repeat (10) @(negedge i_clk);
    check_eq("rr_no_status", start_cnt, s0);
    check_eq("rr_idle", 32'(o_busy), 0);
    do_frame(8'h03, 8'h04, 8'h20, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
